// File: rtl/hack_memory.sv
// ---------------------------------------------------------------------------
// hack_memory -- data memory subsystem of the Hack computer.
//
// Purpose:
//   Implements the CPU-visible data address space of the Hack platform:
//     0x0000-0x3FFF  RAM     (16K words, read/write)
//     0x4000-0x5FFF  SCREEN  (8K words, read/write, also scanned for video)
//     0x6000         KBD     (keyboard register, read-only for the CPU)
//     0x6001-0x7FFF  unmapped (reads give 0, writes are dropped)
//   The CPU port reads combinationally so inM is valid in the same cycle as
//   addressM. The video scanner has its own registered read port into the
//   SCREEN array.
//
// Configuration:
//   `HACK_MEMORY_RANGE_TRAP_EN  when defined, the first CPU write to an
//                               address >= 0x6000 outside reset sets a sticky
//                               bad_access flag and captures the address in
//                               bad_addr. When undefined both outputs are
//                               tied to zero and no trap logic exists.
//
// Ports:
//   clock       in   1   rising-edge clock for all state
//   reset       in   1   synchronous, active-high reset
//   in          in  16   CPU write data (outM)
//   load        in   1   CPU write enable (writeM)
//   address     in  15   CPU word address (addressM)
//   out         out 16   CPU read data (inM), combinational
//   key_valid   in   1   keyboard event strobe
//   key_code    in  16   Hack key code, 0 = all keys released
//   key_ready   out  1   keyboard events accepted (low only during reset)
//   scr_addr    in  13   video scanner word address
//   scr_data    out 16   video scanner read data, 1-cycle latency
//   bad_access  out  1   sticky illegal-write flag
//   bad_addr    out 15   address of the first illegal write
// ---------------------------------------------------------------------------
module hack_memory (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] in,
   input  logic        load,
   input  logic [14:0] address,
   output logic [15:0] out,
   input  logic        key_valid,
   input  logic [15:0] key_code,
   output logic        key_ready,
   input  logic [12:0] scr_addr,
   output logic [15:0] scr_data,
   output logic        bad_access,
   output logic [14:0] bad_addr
);

   localparam logic [14:0] KBD_ADDR = 15'h6000;

   // Storage arrays. Neither array has a reset: their contents survive
   // reset, which also lets synthesis map them onto memory primitives.
   logic [15:0] ram    [0:16383];
   logic [15:0] screen [0:8191];

   logic [15:0] kbd_reg;

   // Region decode. The two top address bits split the space into four 8K
   // windows: 00/01 are RAM, 10 is SCREEN, 11 holds KBD and the unmapped hole.
   logic is_ram;
   logic is_screen;
   logic is_kbd;
   logic cpu_write;

   always_comb begin
      is_ram    = (address[14] == 1'b0);
      is_screen = (address[14:13] == 2'b10);
      is_kbd    = (address == KBD_ADDR);
      cpu_write = load && !reset;
   end

   // A key event is accepted in every non-reset cycle, so the handshake
   // reduces to the inverse of reset.
   assign key_ready = !reset;

   // RAM write port. CPU writes are suppressed while reset is high so that
   // a reset arriving mid-operation cancels the same-cycle store.
   always_ff @(posedge clock) begin
      if (cpu_write && is_ram) begin
         ram[address[13:0]] <= in;
      end
   end

   // SCREEN write port. The CPU address minus 0x4000 and scr_addr index the
   // same physical word, so only the low 13 address bits are used.
   always_ff @(posedge clock) begin
      if (cpu_write && is_screen) begin
         screen[address[12:0]] <= in;
      end
   end

   // Scanner read port. Sampling the array with a non-blocking update gives
   // read-before-write behaviour when the CPU stores to the same word on the
   // same edge: the scanner sees the value held before that edge.
   always_ff @(posedge clock) begin
      if (reset) begin
         scr_data <= 16'h0000;
      end else begin
         scr_data <= screen[scr_addr];
      end
   end

   // Keyboard register. Only the keyboard can load it; CPU stores to 0x6000
   // never reach it, so a simultaneous key event and CPU write naturally
   // resolve in favour of the key event.
   always_ff @(posedge clock) begin
      if (reset) begin
         kbd_reg <= 16'h0000;
      end else if (key_valid && key_ready) begin
         kbd_reg <= key_code;
      end
   end

   // CPU read mux, purely combinational so inM settles within the cycle.
   always_comb begin
      out = 16'h0000;
      if (is_ram) begin
         out = ram[address[13:0]];
      end else if (is_screen) begin
         out = screen[address[12:0]];
      end else if (is_kbd) begin
         out = kbd_reg;
      end
   end

`ifdef HACK_MEMORY_RANGE_TRAP_EN
   // Illegal-write trap. Any store at or above 0x6000 (KBD or the unmapped
   // hole) is a software bug; the first one is latched and later ones are
   // ignored so the captured address points at the original offender.
   logic        trap_hit;
   logic        bad_access_q;
   logic [14:0] bad_addr_q;

   always_comb begin
      trap_hit = cpu_write && (address >= KBD_ADDR) && !bad_access_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         bad_access_q <= 1'b0;
         bad_addr_q   <= 15'h0000;
      end else if (trap_hit) begin
         bad_access_q <= 1'b1;
         bad_addr_q   <= address;
      end
   end

   assign bad_access = bad_access_q;
   assign bad_addr   = bad_addr_q;
`else
   // Trap-less build: outputs are constant and no trap state exists.
   assign bad_access = 1'b0;
   assign bad_addr   = 15'h0000;
`endif

endmodule

// File: tb/tb_hack_memory.sv
// ---------------------------------------------------------------------------
// tb_hack_memory -- self-checking bench for hack_memory.
//
// Directed steps cover the main address-map behaviours, followed by a run of
// random traffic. Expected values come from a reference model that holds the
// memory map as sparse associative arrays indexed by plain integer addresses.
// ---------------------------------------------------------------------------
module tb_hack_memory;

   logic        clock = 1'b0;
   logic        reset;
   logic [15:0] din;
   logic        load;
   logic [14:0] address;
   logic [15:0] dout;
   logic        key_valid;
   logic [15:0] key_code;
   logic        key_ready;
   logic [12:0] scr_addr;
   logic [15:0] scr_data;
   logic        bad_access;
   logic [14:0] bad_addr;

   int errors = 0;
   int checks = 0;

   hack_memory dut (
      .clock      (clock),
      .reset      (reset),
      .in         (din),
      .load       (load),
      .address    (address),
      .out        (dout),
      .key_valid  (key_valid),
      .key_code   (key_code),
      .key_ready  (key_ready),
      .scr_addr   (scr_addr),
      .scr_data   (scr_data),
      .bad_access (bad_access),
      .bad_addr   (bad_addr)
   );

   always #5 clock = ~clock;

   // Reference model state: words are only known once written.
   logic [15:0] ram_m [int];
   logic [15:0] scr_m [int];
   logic [15:0] kbd_m       = 16'h0000;
   logic        bad_m       = 1'b0;
   int          bad_addr_m  = 0;
   logic [15:0] scr_exp     = 16'h0000;
   bit          scr_exp_ok  = 1'b0;

   int ram_pool [16];
   int scr_pool [16];

   task automatic checkValue(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Model read of the CPU address space; returns 0 when the word was never
   // written and therefore has no defined value.
   function automatic bit modelRead(input int a, output logic [15:0] v);
      v = 16'h0000;
      if (a < 'h4000) begin
         if (!ram_m.exists(a)) return 1'b0;
         v = ram_m[a];
      end else if (a < 'h6000) begin
         if (!scr_m.exists(a - 'h4000)) return 1'b0;
         v = scr_m[a - 'h4000];
      end else if (a == 'h6000) begin
         v = kbd_m;
      end
      return 1'b1;
   endfunction

   task automatic checkOutput(input string tag);
      logic [15:0] v;
      if (modelRead(int'(address), v)) checkValue({tag, ":out"}, dout, v);
      if (scr_exp_ok) checkValue({tag, ":scr_data"}, scr_data, scr_exp);
      checkValue({tag, ":bad_access"}, {15'h0, bad_access}, {15'h0, bad_m});
      checkValue({tag, ":bad_addr"}, {1'b0, bad_addr}, 16'(bad_addr_m));
   endtask

   // One clock cycle: drive inputs away from the edge, update the model with
   // the effect of the edge, then compare shortly after it.
   task automatic applyStimulus(input string tag, input bit rst, input bit ld,
                                input int d, input int a, input bit kv,
                                input int kc, input int sa);
      @(negedge clock);
      reset     = rst;
      load      = ld;
      din       = 16'(d);
      address   = 15'(a);
      key_valid = kv;
      key_code  = 16'(kc);
      scr_addr  = 13'(sa);
      #1;
      checkValue({tag, ":key_ready"}, {15'h0, key_ready}, {15'h0, !rst});
      @(posedge clock);
      if (rst) begin
         scr_exp_ok = 1'b1;
         scr_exp    = 16'h0000;
      end else begin
         scr_exp_ok = scr_m.exists(sa);
         scr_exp    = scr_exp_ok ? scr_m[sa] : 16'h0000;
      end
      if (!rst && ld) begin
         if (a < 'h4000) ram_m[a] = 16'(d);
         else if (a < 'h6000) scr_m[a - 'h4000] = 16'(d);
      end
      if (rst) kbd_m = 16'h0000;
      else if (kv) kbd_m = 16'(kc);
`ifdef HACK_MEMORY_RANGE_TRAP_EN
      if (rst) begin
         bad_m      = 1'b0;
         bad_addr_m = 0;
      end else if (ld && a >= 'h6000 && !bad_m) begin
         bad_m      = 1'b1;
         bad_addr_m = a;
      end
`endif
      #1;
      checkOutput(tag);
   endtask

   initial begin
      int kind;
      int a;
      reset = 1'b1; load = 1'b0; din = '0; address = '0;
      key_valid = 1'b0; key_code = '0; scr_addr = '0;

      // Reset state: keyboard register, scr_data and trap outputs cleared.
      applyStimulus("reset", 1, 0, 0, 'h6000, 0, 0, 0);
      checkValue("reset_kbd", dout, 16'h0000);
      checkValue("reset_scr", scr_data, 16'h0000);

      // RAM write then read back, neighbour word untouched.
      applyStimulus("pre0011", 0, 1, 'h5A5A, 'h0011, 0, 0, 0);
      applyStimulus("wr0010", 0, 1, 'h1234, 'h0010, 0, 0, 0);
      applyStimulus("rd0010", 0, 0, 0, 'h0010, 0, 0, 0);
      checkValue("ram_readback", dout, 16'h1234);
      applyStimulus("rd0011", 0, 0, 0, 'h0011, 0, 0, 0);
      checkValue("ram_neighbour", dout, 16'h5A5A);
      applyStimulus("rd0010b", 0, 0, 0, 'h0010, 0, 0, 0);
      checkValue("ram_hold", dout, 16'h1234);

      // SCREEN write, scanner read, aliasing and read-before-write collision.
      applyStimulus("wr4000", 0, 1, 'hFFFF, 'h4000, 0, 0, 0);
      applyStimulus("scan0", 0, 0, 0, 'h4000, 0, 0, 0);
      checkValue("scr_latency", scr_data, 16'hFFFF);
      checkValue("scr_alias", dout, 16'hFFFF);
      applyStimulus("collide", 0, 1, 'h1111, 'h4000, 0, 0, 0);
      checkValue("scr_collide_old", scr_data, 16'hFFFF);
      applyStimulus("after", 0, 0, 0, 'h4000, 0, 0, 0);
      checkValue("scr_collide_new", scr_data, 16'h1111);

      // Keyboard press and release.
      applyStimulus("key41", 0, 0, 0, 'h6000, 1, 'h0041, 0);
      checkValue("kbd_press", dout, 16'h0041);
      applyStimulus("key00", 0, 0, 0, 'h6000, 1, 'h0000, 0);
      checkValue("kbd_release", dout, 16'h0000);

      // Key event beats a CPU store to KBD; unmapped write dropped.
      applyStimulus("kbdwr", 0, 1, 'hBEEF, 'h6000, 1, 'h0080, 0);
      checkValue("kbd_priority", dout, 16'h0080);
      applyStimulus("wr7000", 0, 1, 'hBEEF, 'h7000, 0, 0, 0);
      applyStimulus("rd7000", 0, 0, 0, 'h7000, 0, 0, 0);
      checkValue("unmapped_read", dout, 16'h0000);

      // Trap behaviour from a clean reset.
      applyStimulus("trapreset", 1, 0, 0, 'h0010, 0, 0, 0);
      applyStimulus("wr6005", 0, 1, 'h0001, 'h6005, 0, 0, 0);
      applyStimulus("wr7fff", 0, 1, 'h0002, 'h7FFF, 0, 0, 0);
`ifdef HACK_MEMORY_RANGE_TRAP_EN
      checkValue("trap_flag", {15'h0, bad_access}, 16'h0001);
      checkValue("trap_addr", {1'b0, bad_addr}, 16'h6005);
`else
      checkValue("notrap_flag", {15'h0, bad_access}, 16'h0000);
      checkValue("notrap_addr", {1'b0, bad_addr}, 16'h0000);
`endif
      // Reset with a same-cycle write and key event: both cancelled.
      applyStimulus("rstwr", 1, 1, 'h0000, 'h0010, 1, 'h0055, 0);
      checkValue("trap_cleared", {15'h0, bad_access}, 16'h0000);
      applyStimulus("rd0010c", 0, 0, 0, 'h0010, 0, 0, 0);
      checkValue("ram_survives_reset", dout, 16'h1234);
      applyStimulus("rdkbd", 0, 0, 0, 'h6000, 0, 0, 0);
      checkValue("key_cancelled", dout, 16'h0000);

      // Random traffic over small address pools so reads hit known words.
      foreach (ram_pool[i]) ram_pool[i] = int'($urandom_range(0, 'h3FFF));
      foreach (scr_pool[i]) scr_pool[i] = int'($urandom_range(0, 'h1FFF));
      foreach (ram_pool[i]) applyStimulus("fill_ram", 0, 1, int'($urandom_range(0, 'hFFFF)), ram_pool[i], 0, 0, 0);
      foreach (scr_pool[i]) applyStimulus("fill_scr", 0, 1, int'($urandom_range(0, 'hFFFF)), 'h4000 + scr_pool[i], 0, 0, scr_pool[i]);

      for (int n = 0; n < 400; n++) begin
         kind = int'($urandom_range(0, 9));
         if (kind < 4) a = ram_pool[$urandom_range(0, 15)];
         else if (kind < 7) a = 'h4000 + scr_pool[$urandom_range(0, 15)];
         else if (kind == 7) a = 'h6000;
         else a = 'h6001 + int'($urandom_range(0, 'h1FFE));
         applyStimulus("rand",
                       $urandom_range(0, 39) == 0,
                       1'($urandom_range(0, 1)),
                       int'($urandom_range(0, 'hFFFF)),
                       a,
                       $urandom_range(0, 3) == 0,
                       ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 'hFFFF)),
                       scr_pool[$urandom_range(0, 15)]);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
